// File: rtl/gpio_bank_6502.sv
// gpio_bank_6502: NPORTS x 8-bit GPIO with direction, synchronised inputs,
// edge-detect interrupt flags and a merged registered IRQ. One-cycle read latency.
// Optional macro GPIO_DEBOUNCE_EN adds a per-bit stable-count debounce of DB_CYCLES.
module gpio_bank_6502 #(
  parameter int NPORTS    = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic [4:0]            addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  irq,
  input  logic [NPORTS*8-1:0]   gpio_i,
  output logic [NPORTS*8-1:0]   gpio_o,
  output logic [NPORTS*8-1:0]   gpio_oe
);

  typedef logic [NPORTS-1:0][7:0] bank_t;

`ifdef GPIO_DEBOUNCE_EN
  // Arming must also cover the debounce preload of c from s2.
  localparam int               ARM_W   = 9;
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(DB_CYCLES + 3);
  localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);
`else
  localparam int               ARM_W   = 2;
  localparam logic [ARM_W-1:0] ARM_MAX = 2'd3;
`endif

  if (NPORTS < 1 || NPORTS > 4) begin : g_nports_check
    $error("gpio_bank_6502: NPORTS must be in 1..4");
  end
  if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_db_check
    $error("gpio_bank_6502: DB_CYCLES must be in 2..255");
  end

  bank_t data_q, data_d;
  bank_t dir_q, dir_d;
  bank_t ie_q, ie_d;
  bank_t iflag_q, iflag_d;
  bank_t edge_sel_q, edge_sel_d;
  bank_t both_q, both_d;
  bank_t s1_q, s1_d;
  bank_t s2_q, s2_d;
  bank_t p_q, p_d;
  bank_t cond;
  logic [7:0]       dout_q, dout_d;
  logic             irq_q, irq_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic             armed;
  logic [7:0]       rd_val, rise, fall, ev;
  logic             sel;

  // Flags may only set once s1/s2/p (and c) hold real pin values.
  assign armed = (arm_q == ARM_MAX);

`ifdef GPIO_DEBOUNCE_EN
  bank_t                        cond_q, cond_d;
  logic [NPORTS-1:0][7:0][7:0]  cnt_q, cnt_d;

  assign cond = cond_q;

  // Debounce: c follows s2 only after DB_CYCLES consecutive differing samples.
  always_comb begin
    cond_d = cond_q;
    cnt_d  = cnt_q;
    for (int p = 0; p < NPORTS; p++) begin
      for (int b = 0; b < 8; b++) begin
        if (!armed) begin
          cond_d[p][b] = s2_q[p][b];
          cnt_d[p][b]  = 8'd0;
        end else if (s2_q[p][b] == cond_q[p][b]) begin
          cnt_d[p][b]  = 8'd0;
        end else if (cnt_q[p][b] == DB_LAST) begin
          cond_d[p][b] = s2_q[p][b];
          cnt_d[p][b]  = 8'd0;
        end else begin
          cnt_d[p][b]  = cnt_q[p][b] + 8'd1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_q <= '0;
      cnt_q  <= '0;
    end else begin
      cond_q <= cond_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign cond = s2_q;
`endif

  // Register writes, read mux, edge detection and flag/IRQ next state.
  always_comb begin
    data_d     = data_q;
    dir_d      = dir_q;
    ie_d       = ie_q;
    iflag_d    = iflag_q;
    edge_sel_d = edge_sel_q;
    both_d     = both_q;
    s1_d       = gpio_i;
    s2_d       = s1_q;
    p_d        = cond;
    arm_d      = armed ? arm_q : arm_q + ARM_W'(1);
    rd_val     = 8'h00;
    rise       = 8'h00;
    fall       = 8'h00;
    ev         = 8'h00;
    sel        = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      sel = (addr[4:3] == 2'(p));
      if (sel && cs && we) begin
        case (addr[2:0])
          3'd0:    data_d[p]     = din;
          3'd1:    dir_d[p]      = din;
          3'd3:    ie_d[p]       = din;
          3'd4:    iflag_d[p]    = iflag_q[p] & ~din;
          3'd5:    edge_sel_d[p] = din;
          3'd6:    both_d[p]     = din;
          default: ;
        endcase
      end
      if (sel) begin
        case (addr[2:0])
          3'd0:    rd_val = data_q[p];
          3'd1:    rd_val = dir_q[p];
          3'd2:    rd_val = cond[p];
          3'd3:    rd_val = ie_q[p];
          3'd4:    rd_val = iflag_q[p];
          3'd5:    rd_val = edge_sel_q[p];
          3'd6:    rd_val = both_q[p];
          default: rd_val = 8'h00;
        endcase
      end
      rise = cond[p] & ~p_q[p];
      fall = ~cond[p] & p_q[p];
      ev   = both_q[p] ? (rise | fall)
                       : ((edge_sel_q[p] & fall) | (~edge_sel_q[p] & rise));
      // Set is applied after the W1C so a coincident event wins.
      if (armed) iflag_d[p] = iflag_d[p] | ev;
    end
    irq_d  = |(iflag_q & ie_q);
    dout_d = (cs && !we) ? rd_val : dout_q;
  end

  // All architectural state; async reset drops every pin to input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      dir_q      <= '0;
      ie_q       <= '0;
      iflag_q    <= '0;
      edge_sel_q <= '0;
      both_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      p_q        <= '0;
      dout_q     <= '0;
      irq_q      <= 1'b0;
      arm_q      <= '0;
    end else begin
      data_q     <= data_d;
      dir_q      <= dir_d;
      ie_q       <= ie_d;
      iflag_q    <= iflag_d;
      edge_sel_q <= edge_sel_d;
      both_q     <= both_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      p_q        <= p_d;
      dout_q     <= dout_d;
      irq_q      <= irq_d;
      arm_q      <= arm_d;
    end
  end

  assign dout    = dout_q;
  assign irq     = irq_q;
  assign gpio_o  = data_q;
  assign gpio_oe = dir_q;

endmodule

// File: tb/tb_gpio_bank_6502.sv
// Directed bench for gpio_bank_6502 (NPORTS=2): register access, edge flags,
// W1C/set priority, arming after reset and asynchronous reset.
module tb_gpio_bank_6502;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [7:0]  din = 8'd0;
  logic [7:0]  dout;
  logic        irq;
  logic [15:0] gpio_i = 16'h0000;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe;

  int total = 0;
  int bad   = 0;
  logic [7:0] v;

  gpio_bank_6502 #(.NPORTS(2), .DB_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .irq     (irq),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int port, input int r, input logic [7:0] val);
    cs = 1'b1; we = 1'b1; addr = {2'(port), 3'(r)}; din = val;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int port, input int r, output logic [7:0] val);
    cs = 1'b1; we = 1'b0; addr = {2'(port), 3'(r)};
    @(posedge clk);
    #1;
    cs = 1'b0;
    val = dout;
  endtask

  initial begin
    // Power-on reset state
    cyc(2);
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    reset = 1'b1;
    cyc(4);

    // Port1 DATA/DIR write and readback
    wr(1, 0, 8'h3C);
    chk("p1_gpio_o", 32'(gpio_o[15:8]), 32'h3C);
    wr(1, 1, 8'hF0);
    chk("p1_gpio_oe", 32'(gpio_oe[15:8]), 32'hF0);
    rd(1, 0, v); chk("p1_data_rd", 32'(v), 32'h3C);
    rd(1, 1, v); chk("p1_dir_rd", 32'(v), 32'hF0);

    // Reserved register and out-of-range port
    wr(0, 7, 8'h55);
    rd(0, 7, v); chk("reg7_rd", 32'(v), 32'h00);
    wr(2, 0, 8'hFF);
    chk("oor_wr_ignored", 32'(gpio_o), 32'h3C00);
    rd(2, 0, v); chk("oor_rd", 32'(v), 32'h00);

    // Rising edge on port0 bit0: flag at edge 3, irq at edge 4
    wr(0, 3, 8'h01);
    wr(0, 5, 8'h00);
    gpio_i[0] = 1'b1;
    cyc(2);
    rd(0, 4, v); chk("rise_flag_e3", 32'(v), 32'h00);
    chk("rise_irq_e3", 32'(irq), 32'h0);
    rd(0, 4, v); chk("rise_flag_e4", 32'(v), 32'h01);
    chk("rise_irq_e4", 32'(irq), 32'h1);
    wr(0, 4, 8'h01);
    chk("w1c_irq_same", 32'(irq), 32'h1);
    cyc(1);
    chk("w1c_irq_next", 32'(irq), 32'h0);
    rd(0, 4, v); chk("w1c_flag", 32'(v), 32'h00);

    // Falling edge with EDGE=0 -> no flag; EDGE=1 rising -> no flag; falling -> flag
    gpio_i[0] = 1'b0;
    cyc(5);
    rd(0, 4, v); chk("fall_edge0", 32'(v), 32'h00);
    wr(0, 5, 8'h01);
    gpio_i[0] = 1'b1;
    cyc(5);
    rd(0, 4, v); chk("rise_edge1", 32'(v), 32'h00);
    chk("rise_edge1_irq", 32'(irq), 32'h0);
    gpio_i[0] = 1'b0;
    cyc(5);
    rd(0, 4, v); chk("fall_edge1", 32'(v), 32'h01);
    wr(0, 4, 8'h01);

    // BOTH on bit7: both edges flag; W1C coincident with an event loses
    wr(0, 3, 8'h80);
    wr(0, 6, 8'h80);
    gpio_i[7] = 1'b1;
    cyc(5);
    rd(0, 4, v); chk("both_rise", 32'(v), 32'h80);
    wr(0, 4, 8'h80);
    gpio_i[7] = 1'b0;
    cyc(3);
    rd(0, 4, v); chk("both_fall", 32'(v), 32'h80);
    wr(0, 4, 8'h80);
    gpio_i[7] = 1'b1;
    rd(0, 4, v); chk("both_cleared", 32'(v), 32'h00);
    rd(0, 4, v); chk("both_pre_set", 32'(v), 32'h00);
    wr(0, 4, 8'h80);
    rd(0, 4, v); chk("set_beats_w1c", 32'(v), 32'h80);
    chk("set_beats_w1c_irq", 32'(irq), 32'h1);

    // PIN reads conditioned input regardless of DIR
    gpio_i = 16'h3CDA;
    cyc(3);
    rd(0, 2, v); chk("pin_p0", 32'(v), 32'hDA);
    rd(1, 2, v); chk("pin_p1_out_dir", 32'(v), 32'h3C);

    // Asynchronous reset mid-cycle
    wr(0, 0, 8'hA5);
    chk("pre_rst_gpio_o", 32'(gpio_o[7:0]), 32'hA5);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_gpio_o", 32'(gpio_o), 32'h0);
    chk("arst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_dout", 32'(dout), 32'h0);

    // Pins held high through reset release -> no spurious flags
    gpio_i = 16'hFFFF;
    cyc(3);
    reset = 1'b1;
    cyc(8);
    rd(0, 4, v); chk("arm_flag_p0", 32'(v), 32'h00);
    rd(1, 4, v); chk("arm_flag_p1", 32'(v), 32'h00);
    chk("arm_irq", 32'(irq), 32'h0);
    rd(0, 2, v); chk("arm_pin_p0", 32'(v), 32'hFF);
    rd(0, 7, v); chk("arm_reg7", 32'(v), 32'h00);
    wr(0, 3, 8'hFF);
    cyc(2);
    chk("arm_irq_ie", 32'(irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short glitch filtered, stable change flagged 19 clocks later
    cyc(20);
    wr(0, 6, 8'h01);
    wr(0, 3, 8'h01);
    gpio_i[0] = 1'b0;
    cyc(10);
    gpio_i[0] = 1'b1;
    cyc(25);
    rd(0, 2, v); chk("db_glitch_pin", 32'(v), 32'hFF);
    rd(0, 4, v); chk("db_glitch_flag", 32'(v), 32'h00);
    gpio_i[0] = 1'b0;
    cyc(18);
    rd(0, 4, v); chk("db_flag_e19", 32'(v), 32'h00);
    rd(0, 4, v); chk("db_flag_e20", 32'(v), 32'h01);
    rd(0, 2, v); chk("db_pin", 32'(v), 32'hFE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
